// File: rtl/dc_ipu_line_scheduler.sv
// dc_ipu_line_scheduler: per-line IPU request sequencer, throttled by display line-buffer credits
module dc_ipu_line_scheduler #(
    parameter int SCR_SIZE_WIDTH = 12,
    parameter int LINE_BUFS      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic [SCR_SIZE_WIDTH-1:0] cfg_screen_height,
    input  logic                      line_consumed,
    output logic                      ctl_valid,
    input  logic                      ctl_ready,
    output logic [SCR_SIZE_WIDTH-1:0] ctl_screen_y,
    input  logic                      ipu_status_done,
    output logic                      busy,
    output logic                      frame_done,
    output logic [3:0]                credits,
    output logic                      err_underrun,
    output logic                      err_frame_overrun
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;
    localparam logic [3:0] FULL      = 4'(LINE_BUFS);

    logic [1:0]                state_q, state_d;
    logic [SCR_SIZE_WIDTH-1:0] y_q, y_d, height_q, height_d;
    logic [3:0]                credits_q, credits_d;
    logic                      err_u_q, err_u_d, err_o_q, err_o_d;
    logic                      accept;

    // Credits only fall on accept, so a raised ctl_valid cannot drop before ctl_ready.
    assign ctl_valid         = (state_q == ISSUE) && (credits_q != 4'd0);
    assign accept            = ctl_valid && ctl_ready;
    assign ctl_screen_y      = y_q;
    assign busy              = state_q != IDLE;
    assign frame_done        = state_q == DONE;
    assign credits           = credits_q;
    assign err_underrun      = err_u_q;
    assign err_frame_overrun = err_o_q;

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        height_d  = height_q;
        credits_d = credits_q;
        err_u_d   = err_u_q;
        err_o_d   = err_o_q | (frame_start && state_q != IDLE);
        if (line_consumed && !accept) begin
            if (credits_q == FULL) err_u_d = 1'b1;
            else credits_d = credits_q + 4'd1;
        end else if (accept && !line_consumed) begin
            credits_d = credits_q - 4'd1;
        end
        case (state_q)
            IDLE: if (frame_start) begin
                height_d  = cfg_screen_height;
                y_d       = '0;
                credits_d = FULL;
                state_d   = (cfg_screen_height == '0) ? DONE : ISSUE;
            end
            ISSUE: state_d = accept ? WAIT_DONE : ISSUE;
            WAIT_DONE: if (ipu_status_done) begin
                if (y_q == height_q - 1'b1) state_d = DONE;
                else begin
                    y_d     = y_q + 1'b1;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            y_q       <= '0;
            height_q  <= '0;
            credits_q <= FULL;
            err_u_q   <= 1'b0;
            err_o_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            height_q  <= height_d;
            credits_q <= credits_d;
            err_u_q   <= err_u_d;
            err_o_q   <= err_o_d;
        end
    end
endmodule

// File: tb/tb_dc_ipu_line_scheduler.sv
// tb_dc_ipu_line_scheduler: directed checks of line sequencing, credits, backpressure and errors
module tb_dc_ipu_line_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic [11:0] cfg_screen_height = '0;
    logic        line_consumed = 1'b0;
    logic        ctl_valid;
    logic        ctl_ready = 1'b0;
    logic [11:0] ctl_screen_y;
    logic        ipu_status_done = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [3:0]  credits;
    logic        err_underrun;
    logic        err_frame_overrun;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dc_ipu_line_scheduler #(.SCR_SIZE_WIDTH(12), .LINE_BUFS(2)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .cfg_screen_height(cfg_screen_height), .line_consumed(line_consumed),
        .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl_screen_y(ctl_screen_y),
        .ipu_status_done(ipu_status_done), .busy(busy), .frame_done(frame_done),
        .credits(credits), .err_underrun(err_underrun), .err_frame_overrun(err_frame_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ctl_ready = 1'b0;
        frame_start = 1'b0;
        line_consumed = 1'b0;
        ipu_status_done = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_frame(input logic [11:0] h);
        cfg_screen_height = h;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Accept the pending request, then pulse done three cycles after the accept.
    task automatic serve_line(input bit consume);
        ctl_ready = 1'b1;
        tick();
        tick();
        tick();
        ipu_status_done = 1'b1;
        line_consumed = consume;
        tick();
        ipu_status_done = 1'b0;
        line_consumed = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ctl_valid !== 1'b0 || ctl_screen_y !== 12'd0 || busy !== 1'b0 || frame_done !== 1'b0 ||
            credits !== 4'd2 || err_underrun !== 1'b0 || err_frame_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b y=%0d busy=%b done=%b credits=%0d eu=%b eo=%b, expected 0 0 0 0 2 0 0",
                     ctl_valid, ctl_screen_y, busy, frame_done, credits, err_underrun, err_frame_overrun);
        end
    endtask

    task automatic test_frame();
        int pulses = 0;
        do_reset();
        ctl_ready = 1'b1;
        start_frame(12'd4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctl_valid !== 1'b1 || ctl_screen_y !== 12'(i) || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL frame_issue line %0d: valid=%b y=%0d done=%b, expected 1 %0d 0",
                         i, ctl_valid, ctl_screen_y, frame_done, i);
            end
            tick();
            checks++;
            if (ctl_valid !== 1'b0 || credits !== 4'd1) begin
                errors++;
                $display("FAIL frame_accept line %0d: valid=%b credits=%0d, expected 0 1", i, ctl_valid, credits);
            end
            tick();
            tick();
            ipu_status_done = 1'b1;
            line_consumed = 1'b1;
            tick();
            ipu_status_done = 1'b0;
            line_consumed = 1'b0;
            if (frame_done === 1'b1) pulses++;
        end
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b1 || credits !== 4'd2) begin
            errors++;
            $display("FAIL frame_done: done=%b busy=%b credits=%0d, expected 1 1 2", frame_done, busy, credits);
        end
        tick();
        if (frame_done === 1'b1) pulses++;
        checks++;
        if (busy !== 1'b0 || pulses != 1 || ctl_screen_y !== 12'd3) begin
            errors++;
            $display("FAIL frame_end: busy=%b pulses=%0d y=%0d, expected 0 1 3", busy, pulses, ctl_screen_y);
        end
    endtask

    task automatic test_credits();
        do_reset();
        start_frame(12'd4);
        serve_line(1'b0);
        serve_line(1'b0);
        ctl_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl_valid !== 1'b0 || ctl_screen_y !== 12'd2 || credits !== 4'd0) begin
                errors++;
                $display("FAIL credit_stall cycle %0d: valid=%b y=%0d credits=%0d, expected 0 2 0",
                         i, ctl_valid, ctl_screen_y, credits);
            end
            tick();
        end
        ctl_ready = 1'b0;
        line_consumed = 1'b1;
        tick();
        line_consumed = 1'b0;
        checks++;
        if (ctl_valid !== 1'b1 || ctl_screen_y !== 12'd2 || credits !== 4'd1) begin
            errors++;
            $display("FAIL credit_resume: valid=%b y=%0d credits=%0d, expected 1 2 1", ctl_valid, ctl_screen_y, credits);
        end
        serve_line(1'b1);
        serve_line(1'b1);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL credit_frame_done: done=%b, expected 1", frame_done);
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        start_frame(12'd2);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ctl_valid !== 1'b1 || ctl_screen_y !== 12'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL backpressure cycle %0d: valid=%b y=%0d busy=%b, expected 1 0 1",
                         i, ctl_valid, ctl_screen_y, busy);
            end
            tick();
        end
        serve_line(1'b1);
        checks++;
        if (ctl_valid !== 1'b1 || ctl_screen_y !== 12'd1) begin
            errors++;
            $display("FAIL backpressure_next: valid=%b y=%0d, expected 1 1", ctl_valid, ctl_screen_y);
        end
        serve_line(1'b1);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_done: done=%b, expected 1", frame_done);
        end
        tick();
    endtask

    task automatic test_errors();
        do_reset();
        start_frame(12'd4);
        serve_line(1'b1);
        ctl_ready = 1'b0;
        start_frame(12'd7);
        checks++;
        if (err_frame_overrun !== 1'b1 || ctl_valid !== 1'b1 || ctl_screen_y !== 12'd1 || err_underrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun: eo=%b valid=%b y=%0d eu=%b, expected 1 1 1 0",
                     err_frame_overrun, ctl_valid, ctl_screen_y, err_underrun);
        end
        serve_line(1'b1);
        serve_line(1'b1);
        checks++;
        if (ctl_screen_y !== 12'd3 || ctl_valid !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL overrun_continue: y=%0d valid=%b done=%b, expected 3 1 0", ctl_screen_y, ctl_valid, frame_done);
        end
        serve_line(1'b1);
        checks++;
        if (frame_done !== 1'b1 || ctl_screen_y !== 12'd3) begin
            errors++;
            $display("FAIL overrun_end: done=%b y=%0d, expected 1 3", frame_done, ctl_screen_y);
        end
        tick();
        line_consumed = 1'b1;
        tick();
        line_consumed = 1'b0;
        checks++;
        if (err_underrun !== 1'b1 || credits !== 4'd2 || err_frame_overrun !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL underrun: eu=%b credits=%0d eo=%b busy=%b, expected 1 2 1 0",
                     err_underrun, credits, err_frame_overrun, busy);
        end
    endtask

    task automatic test_zero_height();
        do_reset();
        start_frame(12'd0);
        checks++;
        if (ctl_valid !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_height: valid=%b done=%b busy=%b, expected 0 1 1", ctl_valid, frame_done, busy);
        end
        tick();
        checks++;
        if (ctl_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_height_idle: valid=%b done=%b busy=%b, expected 0 0 0", ctl_valid, frame_done, busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_frame(12'd3);
        ctl_ready = 1'b1;
        line_consumed = 1'b1;
        tick();
        line_consumed = 1'b0;
        checks++;
        if (credits !== 4'd2 || err_underrun !== 1'b0 || ctl_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle: credits=%0d eu=%b valid=%b, expected 2 0 0", credits, err_underrun, ctl_valid);
        end
        tick();
        ipu_status_done = 1'b1;
        tick();
        ipu_status_done = 1'b0;
        serve_line(1'b0);
        checks++;
        if (ctl_valid !== 1'b1 || ctl_screen_y !== 12'd2 || credits !== 4'd1) begin
            errors++;
            $display("FAIL b2b_line2: valid=%b y=%0d credits=%0d, expected 1 2 1", ctl_valid, ctl_screen_y, credits);
        end
        serve_line(1'b0);
        checks++;
        if (frame_done !== 1'b1 || credits !== 4'd0) begin
            errors++;
            $display("FAIL b2b_done: done=%b credits=%0d, expected 1 0", frame_done, credits);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        start_frame(12'd4);
        serve_line(1'b1);
        serve_line(1'b1);
        ctl_ready = 1'b1;
        tick();
        checks++;
        if (ctl_valid !== 1'b0 || busy !== 1'b1 || ctl_screen_y !== 12'd2) begin
            errors++;
            $display("FAIL pre_reset: valid=%b busy=%b y=%0d, expected 0 1 2", ctl_valid, busy, ctl_screen_y);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ctl_valid !== 1'b0 || busy !== 1'b0 || ctl_screen_y !== 12'd0 || credits !== 4'd2 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b busy=%b y=%0d credits=%0d done=%b, expected 0 0 0 2 0",
                     ctl_valid, busy, ctl_screen_y, credits, frame_done);
        end
        tick();
        reset = 1'b0;
        ipu_status_done = 1'b1;
        tick();
        ipu_status_done = 1'b0;
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done=%b busy=%b, expected 0 0", frame_done, busy);
        end
        start_frame(12'd4);
        checks++;
        if (ctl_valid !== 1'b1 || ctl_screen_y !== 12'd0) begin
            errors++;
            $display("FAIL restart: valid=%b y=%0d, expected 1 0", ctl_valid, ctl_screen_y);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_credits();
        test_backpressure();
        test_errors();
        test_zero_height();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
